// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard decoder: frame states,
// prefix byte values and the device-response filter.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_e;

    localparam logic [7:0] PS2_EXT      = 8'hE0;
    localparam logic [7:0] PS2_REL      = 8'hF0;
    localparam logic [7:0] PS2_PAUSE    = 8'hE1;
    localparam logic [2:0] PS2_SKIP_LEN = 3'd7;

    // Bytes a keyboard sends as command replies rather than key codes.
    function automatic logic is_response(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Bundle of the raw PS/2 lines and the decoded key outputs. The master side
// drives the keyboard lines and observes events; the decoder is the slave.
interface ps2_key_decoder_if;
    logic        ps2_kbd_clk;
    logic        ps2_kbd_data;
    logic [10:0] ps2_key;
    logic        parity_err;

    modport master (
        output ps2_kbd_clk,
        output ps2_kbd_data,
        input  ps2_key,
        input  parity_err
    );

    modport slave (
        input  ps2_kbd_clk,
        input  ps2_kbd_data,
        output ps2_key,
        output parity_err
    );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a run-length filter: the output follows
// the input only after FILTER_LEN consecutive samples at the new level.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic srst,
    input  logic line_i,
    output logic line_o
);
    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
    localparam logic [CW-1:0] RUN_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    sync_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] run_q, run_d;

    always_comb begin
        filt_d = filt_q;
        run_d  = '0;
        // Any sample matching the current output restarts the run, so short glitches vanish.
        if (sync_q[1] != filt_q) begin
            if (run_q == RUN_LAST) begin
                filt_d = sync_q[1];
            end else begin
                run_d = run_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            run_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            filt_q <= filt_d;
            run_q  <= run_d;
        end
    end

    assign line_o = filt_q;
endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: filters the raw lines, deframes 11-bit frames and
// folds E0/F0/E1 prefixes into one toggle-flagged key event per key code.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic               clk_sys,
    input  logic               reset,
    ps2_key_decoder_if.slave   bus
);
    localparam int IW = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT);

    logic [1:0] raw_lines;
    logic [1:0] filt_lines;
    logic       clk_f, data_f;

    assign raw_lines = {bus.ps2_kbd_data, bus.ps2_kbd_clk};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
                .clk    (clk_sys),
                .srst   (reset),
                .line_i (raw_lines[gi]),
                .line_o (filt_lines[gi])
            );
        end
    endgenerate

    assign clk_f  = filt_lines[0];
    assign data_f = filt_lines[1];

    frame_state_e  state_q, state_d;
    logic          clk_prev_q;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          ext_q, ext_d;
    logic          rel_q, rel_d;
    logic [2:0]    skip_q, skip_d;
    logic [10:0]   key_q, key_d;
    logic          perr_q, perr_d;

    logic fall, timeout, frame_ok;
    logic shift_en, parity_en, stop_en, timer_run;

    assign fall     = clk_prev_q & ~clk_f;
    assign timeout  = (state_q != ST_IDLE) && (idle_q == IDLE_LIMIT);
    assign frame_ok = (^{shift_q, parity_q}) & data_f;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = ST_IDLE;
        end else if (fall) begin
            case (state_q)
                ST_IDLE:   if (!data_f) state_d = ST_DATA;
                ST_DATA:   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        shift_en  = (state_q == ST_DATA)   && fall && !timeout;
        parity_en = (state_q == ST_PARITY) && fall && !timeout;
        stop_en   = (state_q == ST_STOP)   && fall && !timeout;
        timer_run = (state_q != ST_IDLE);
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        idle_d    = (!timer_run || fall || timeout) ? '0 : idle_q + IW'(1);
        if (timeout) begin
            bit_cnt_d = '0;
            shift_d   = '0;
        end else begin
            if (shift_en) begin
                shift_d   = {data_f, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            if (parity_en) begin
                parity_d = data_f;
            end
        end
    end

    // Prefix and event logic acts once per frame, on the stop-bit sample.
    always_comb begin
        ext_d  = ext_q;
        rel_d  = rel_q;
        skip_d = skip_q;
        key_d  = key_q;
        perr_d = 1'b0;
        if (stop_en) begin
            if (!frame_ok) begin
                perr_d = 1'b1;
                ext_d  = 1'b0;
                rel_d  = 1'b0;
            end else if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (shift_q == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == PS2_REL) begin
                rel_d = 1'b1;
            end else if (shift_q == PS2_PAUSE) begin
                skip_d = PS2_SKIP_LEN;
            end else if (!ext_q && !rel_q && is_response(shift_q)) begin
                skip_d = skip_q;
            end else begin
                key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
                ext_d = 1'b0;
                rel_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_prev_q <= 1'b1;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            idle_q     <= '0;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            skip_q     <= '0;
            key_q      <= '0;
            perr_q     <= 1'b0;
        end else begin
            clk_prev_q <= clk_f;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            idle_q     <= idle_d;
            ext_q      <= ext_d;
            rel_q      <= rel_d;
            skip_q     <= skip_d;
            key_q      <= key_d;
            perr_q     <= perr_d;
        end
    end

    assign bus.ps2_key    = key_q;
    assign bus.parity_err = perr_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames with
// hand-computed expected key events and error pulses.
module tb_ps2_key_decoder;
    localparam int FLT = 8;
    localparam int TO  = 1000;

    logic clk;
    logic rst;
    ps2_key_decoder_if bus_if ();

    ps2_key_decoder #(.FILTER_LEN(FLT), .TIMEOUT(TO)) dut (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int ev_cnt   = 0;
    int perr_cyc = 0;
    logic tog_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst && (bus_if.ps2_key[10] !== tog_prev)) ev_cnt <= ev_cnt + 1;
        if (!rst && bus_if.parity_err === 1'b1) perr_cyc <= perr_cyc + 1;
        tog_prev <= bus_if.ps2_key[10];
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v, input bit glitch);
        bus_if.ps2_kbd_data = v;
        if (glitch) begin
            bus_if.ps2_kbd_clk = 1'b0; cyc(1); bus_if.ps2_kbd_clk = 1'b1; cyc(9);
        end else cyc(10);
        bus_if.ps2_kbd_clk = 1'b0; cyc(20);
        bus_if.ps2_kbd_clk = 1'b1;
        if (glitch) begin
            cyc(4); bus_if.ps2_kbd_clk = 1'b0; cyc(1); bus_if.ps2_kbd_clk = 1'b1; cyc(5);
        end else cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
        logic p;
        p = (~^b) ^ bad_par;
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
        send_bit(p, glitch);
        send_bit(~bad_stop, glitch);
        bus_if.ps2_kbd_data = 1'b1;
        cyc(20);
        $display("frame %02h bad_par=%0d bad_stop=%0d glitch=%0d -> key=%03h", b, bad_par, bad_stop, glitch, bus_if.ps2_key);
    endtask

    int e0, p0;

    initial begin
        bus_if.ps2_kbd_clk  = 1'b1;
        bus_if.ps2_kbd_data = 1'b1;
        rst = 1'b1;
        cyc(5);
        chk("reset_key", 32'(bus_if.ps2_key), 32'h0);
        chk("reset_perr", 32'(bus_if.parity_err), 32'h0);
        rst = 1'b0;
        cyc(5);

        // Make code 1C: toggle 0->1, pressed.
        e0 = ev_cnt; p0 = perr_cyc;
        send_frame(8'h1C, 0, 0, 0);
        chk("make_1c", 32'(bus_if.ps2_key), 32'(11'b1_1_0_00011100));
        chk("make_1c_events", ev_cnt - e0, 1);
        chk("make_1c_perr", perr_cyc - p0, 0);

        // Break F0 1C.
        e0 = ev_cnt;
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h1C, 0, 0, 0);
        chk("break_1c", 32'(bus_if.ps2_key), 32'(11'b0_0_0_00011100));
        chk("break_1c_events", ev_cnt - e0, 1);

        // Extended break, both prefix orders.
        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h75, 0, 0, 0);
        chk("e0f0_75", 32'(bus_if.ps2_key), 32'h575);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'h75, 0, 0, 0);
        chk("f0e0_75", 32'(bus_if.ps2_key), 32'h175);

        // Parity error drops the byte and pulses once.
        e0 = ev_cnt; p0 = perr_cyc;
        send_frame(8'h1C, 1, 0, 0);
        chk("bad_par_key", 32'(bus_if.ps2_key), 32'h175);
        chk("bad_par_pulse", perr_cyc - p0, 1);
        chk("bad_par_events", ev_cnt - e0, 0);
        send_frame(8'h1B, 0, 0, 0);
        chk("after_err_1b", 32'(bus_if.ps2_key), 32'h61B);

        // Typematic repeat yields a fresh event.
        e0 = ev_cnt;
        send_frame(8'h1B, 0, 0, 0);
        chk("typematic_1b", 32'(bus_if.ps2_key), 32'h21B);
        chk("typematic_events", ev_cnt - e0, 1);

        // Partial frame abandoned by timeout.
        e0 = ev_cnt;
        send_bit(1'b0, 0);
        for (int i = 0; i < 7; i++) send_bit(1'b1, 0);
        cyc(TO + 10);
        send_frame(8'h29, 0, 0, 0);
        chk("timeout_29", 32'(bus_if.ps2_key), 32'h629);
        chk("timeout_events", ev_cnt - e0, 1);

        // Pause sequence swallowed, then 5A.
        e0 = ev_cnt;
        send_frame(8'hE1, 0, 0, 0);
        send_frame(8'h14, 0, 0, 0);
        send_frame(8'h77, 0, 0, 0);
        send_frame(8'hE1, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h14, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h77, 0, 0, 0);
        send_frame(8'h5A, 0, 0, 0);
        chk("pause_5a", 32'(bus_if.ps2_key), 32'h25A);
        chk("pause_events", ev_cnt - e0, 1);

        // Device ACK is not a key.
        e0 = ev_cnt;
        send_frame(8'hFA, 0, 0, 0);
        chk("ack_fa_key", 32'(bus_if.ps2_key), 32'h25A);
        chk("ack_fa_events", ev_cnt - e0, 0);

        // Clock-line glitches are filtered out.
        e0 = ev_cnt;
        send_frame(8'h16, 0, 0, 1);
        chk("glitch_16", 32'(bus_if.ps2_key), 32'h616);
        chk("glitch_events", ev_cnt - e0, 1);

        // Stop-bit error clears a pending E0.
        e0 = ev_cnt; p0 = perr_cyc;
        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'h33, 0, 1, 0);
        chk("bad_stop_pulse", perr_cyc - p0, 1);
        send_frame(8'h1C, 0, 0, 0);
        chk("ext_cleared_1c", 32'(bus_if.ps2_key), 32'h21C);
        chk("bad_stop_events", ev_cnt - e0, 1);

        // Reset in the middle of a frame.
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(((8'h1C >> i) & 8'h01) != 0, 0);
        rst = 1'b1;
        cyc(3);
        chk("midrst_key", 32'(bus_if.ps2_key), 32'h0);
        chk("midrst_perr", 32'(bus_if.parity_err), 32'h0);
        rst = 1'b0;
        e0 = ev_cnt;
        for (int i = 4; i < 8; i++) send_bit(((8'h1C >> i) & 8'h01) != 0, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        cyc(TO + 10);
        chk("midrst_no_event", ev_cnt - e0, 0);
        send_frame(8'h1C, 0, 0, 0);
        chk("post_rst_1c", 32'(bus_if.ps2_key), 32'h61C);
        chk("post_rst_events", ev_cnt - e0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
